// File: rtl/tape_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : tape_arbiter_if
// Brief    : One requester's tape access channel (request, write data,
//            acknowledge and read return).
// Revision : 1.0 - initial release
// ============================================================================
interface tape_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ack;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  // Requester side
  modport master (output req, we, addr, wdata, input ack, rvalid, rdata);
  // Arbiter side
  modport slave  (input req, we, addr, wdata, output ack, rvalid, rdata);
endinterface
`default_nettype wire

// File: rtl/tape_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tape_arbiter
// Brief    : Single-port tape RAM arbiter between the execution core and the
//            host/debug port. Core has default priority; a starvation guard
//            bounds host wait and a host lock gives atomic host bursts.
// Revision : 1.0 - initial release
// ============================================================================
module tape_arbiter #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  tape_arbiter_if.slave         core,
  tape_arbiter_if.slave         host,
  input  logic                  host_lock,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int          WAIT_W     = $clog2(HOST_MAX_WAIT + 1);
  localparam [WAIT_W-1:0] C_WAIT_MAX = WAIT_W'(HOST_MAX_WAIT);

  localparam logic [0:0] ST_CORE_PRI    = 1'b0;
  localparam logic [0:0] ST_HOST_LOCKED = 1'b1;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CORE = 2'd1;
  localparam logic [1:0] OWN_HOST = 2'd2;

  logic [0:0]            r_state;
  logic [0:0]            w_state_next;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic [1:0]            r_rd_owner;
  logic [ADDR_WIDTH-1:0] r_addr_hold;
  logic [DATA_WIDTH-1:0] r_wdata_hold;
  logic                  w_locked;
  logic                  w_grant_core;
  logic                  w_grant_host;

  // Lock only excludes the core while host_lock is still asserted, so the
  // release cycle already arbitrates with normal core priority.
  assign w_locked = (r_state == ST_HOST_LOCKED) && host_lock;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_CORE_PRI;
    else          r_state <= w_state_next;
  end

  // Next-state logic: enter lock on a locked host grant, leave when lock drops
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_CORE_PRI:    if (w_grant_host && host_lock) w_state_next = ST_HOST_LOCKED;
      ST_HOST_LOCKED: if (!host_lock) w_state_next = ST_CORE_PRI;
      default:        w_state_next = ST_CORE_PRI;
    endcase
  end

  // Output logic: grant selection and RAM port steering; all strobes are
  // held low while reset is asserted
  always_comb begin
    w_grant_core = 1'b0;
    w_grant_host = 1'b0;
    if (w_locked) begin
      w_grant_host = host.req;
    end else if (host.req && (!core.req || (r_wait_cnt == C_WAIT_MAX))) begin
      w_grant_host = 1'b1;
    end else begin
      w_grant_core = core.req;
    end
    if (!reset_n) begin
      w_grant_core = 1'b0;
      w_grant_host = 1'b0;
    end

    ram_we    = 1'b0;
    ram_addr  = r_addr_hold;
    ram_wdata = r_wdata_hold;
    if (w_grant_core) begin
      ram_we    = core.we;
      ram_addr  = core.addr;
      ram_wdata = core.wdata;
    end else if (w_grant_host) begin
      ram_we    = host.we;
      ram_addr  = host.addr;
      ram_wdata = host.wdata;
    end
  end

  assign core.ack    = w_grant_core;
  assign host.ack    = w_grant_host;
  assign core.rvalid = (r_rd_owner == OWN_CORE);
  assign host.rvalid = (r_rd_owner == OWN_HOST);
  assign core.rdata  = ram_rdata;
  assign host.rdata  = ram_rdata;

  // Host starvation counter: counts cycles the host loses to the core
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= '0;
    end else if (w_grant_host || !host.req) begin
      r_wait_cnt <= '0;
    end else if (w_grant_core && (r_wait_cnt != C_WAIT_MAX)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Read-return owner tracking plus address/data hold for idle cycles
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_owner   <= OWN_NONE;
      r_addr_hold  <= '0;
      r_wdata_hold <= '0;
    end else begin
      r_addr_hold  <= ram_addr;
      r_wdata_hold <= ram_wdata;
      if (w_grant_core && !core.we)      r_rd_owner <= OWN_CORE;
      else if (w_grant_host && !host.we) r_rd_owner <= OWN_HOST;
      else                               r_rd_owner <= OWN_NONE;
    end
  end

endmodule
`default_nettype wire
